// File: rtl/airi5c_prebuf_hw_fifo.sv
// airi5c_prebuf_hw_fifo
// Halfword-granular prefetch buffer between instruction fetch and decode.
// Fetch writes whole words; decode sees a combinational two-halfword window
// starting at any halfword position and consumes 0, 1 or 2 halfwords a cycle.
// Optional feature macro: AIRI5C_PREBUF_ERR_EN (per-entry fetch bus error bit).
module airi5c_prebuf_hw_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int HW_WIDTH   = 16
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic                              clear_i,
    input  logic                              we_i,
    input  logic [2*HW_WIDTH-1:0]             data_i,
`ifdef AIRI5C_PREBUF_ERR_EN
    input  logic                              err_i,
    output logic [1:0]                        err_o,
`endif
    output logic                              free_o,
    input  logic [1:0]                        consume_i,
    output logic [2*HW_WIDTH-1:0]             data_o,
    output logic [1:0]                        hw_avail_o,
    output logic [$clog2(2*FIFO_DEPTH):0]     level_o,
    output logic                              hfull_o
);

    localparam int AW  = $clog2(FIFO_DEPTH);   // entry index width
    localparam int WPW = AW + 1;               // word pointer width
    localparam int RPW = AW + 2;               // halfword pointer / level width

    logic [WPW-1:0]        r_wr_ptr;
    logic [RPW-1:0]        r_rd_ptr;
    logic [2*HW_WIDTH-1:0] r_mem [FIFO_DEPTH];

    logic [RPW-1:0]        w_level;
    logic                  w_free;
    logic [1:0]            w_avail;
    logic [1:0]            w_req;
    logic [1:0]            w_n;
    logic                  w_wr_en;
    logic [AW:0]           w_hw0;
    logic [AW:0]           w_hw1;
    logic [2*HW_WIDTH-1:0] w_word0;
    logic [2*HW_WIDTH-1:0] w_word1;
    logic [HW_WIDTH-1:0]   w_lane0;
    logic [HW_WIDTH-1:0]   w_lane1;

    // Select one halfword lane of a stored word.
    function automatic logic [HW_WIDTH-1:0] pick_lane(input logic [2*HW_WIDTH-1:0] word,
                                                      input logic hi);
        return hi ? word[2*HW_WIDTH-1:HW_WIDTH] : word[HW_WIDTH-1:0];
    endfunction

    // Fill level and flow-control flags from the pre-edge pointers.
    assign w_level = {r_wr_ptr, 1'b0} - r_rd_ptr;
    assign w_free  = (w_level <= RPW'(2*FIFO_DEPTH-2));
    assign w_avail = (w_level >= RPW'(2)) ? 2'd2 : w_level[1:0];
    assign w_req   = (consume_i == 2'd3) ? 2'd2 : consume_i;
    assign w_n     = (w_req > w_avail) ? w_avail : w_req;
    assign w_wr_en = we_i && w_free && !clear_i;

    assign free_o     = w_free;
    assign hw_avail_o = w_avail;
    assign level_o    = w_level;
    assign hfull_o    = (w_level >= RPW'(FIFO_DEPTH));

    // Halfword positions of the two window lanes; the +1 wraps entry D-1 -> 0.
    assign w_hw0   = r_rd_ptr[AW:0];
    assign w_hw1   = w_hw0 + 1'b1;
    assign w_word0 = r_mem[w_hw0[AW:1]];
    assign w_word1 = r_mem[w_hw1[AW:1]];

    // Build the window, forcing lanes beyond the valid count to zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_lane0 = '0;
        w_lane1 = '0;
        if (w_avail != 2'd0) w_lane0 = pick_lane(w_word0, w_hw0[0]);
        if (w_avail == 2'd2) w_lane1 = pick_lane(w_word1, w_hw1[0]);
    end

    assign data_o = {w_lane1, w_lane0};

    // Pointer update: clear dominates, otherwise write and consume both apply.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            r_rd_ptr <= r_rd_ptr + RPW'(w_n);
        end
    end

    // Word storage write port.
    always_ff @(posedge clk_i) begin
        // NOTE: the array has no reset; the pointers alone define which entries are valid.
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
    end

`ifdef AIRI5C_PREBUF_ERR_EN
    logic r_err [FIFO_DEPTH];

    // One bus-error bit stored alongside each word.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) r_err[r_wr_ptr[AW-1:0]] <= err_i;
    end

    assign err_o[0] = (w_avail != 2'd0) && r_err[w_hw0[AW:1]];
    assign err_o[1] = (w_avail == 2'd2) && r_err[w_hw1[AW:1]];
`endif

endmodule

// File: tb/tb_airi5c_prebuf_hw_fifo.sv
// Testbench for airi5c_prebuf_hw_fifo (D=4, 16-bit halfwords).
// A halfword queue holds what the buffer should contain; it is pushed when a
// write is accepted and popped as halfwords are consumed. Define
// AIRI5C_PREBUF_ERR_EN to also exercise the error bits.
module tb_airi5c_prebuf_hw_fifo;

    localparam int D  = 4;
    localparam int HW = 16;

    logic          clk = 1'b0;
    logic          rstn_i;
    logic          clear_i;
    logic          we_i;
    logic [31:0]   data_i;
    logic          free_o;
    logic [1:0]    consume_i;
    logic [31:0]   data_o;
    logic [1:0]    hw_avail_o;
    logic [3:0]    level_o;
    logic          hfull_o;
    logic          err_in;
    logic [1:0]    err_out;

    int checks = 0;
    int errors = 0;

    logic [HW-1:0] q_hw[$];
    logic          q_err[$];

    airi5c_prebuf_hw_fifo #(.FIFO_DEPTH(D), .HW_WIDTH(HW)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn_i),
        .clear_i    (clear_i),
        .we_i       (we_i),
        .data_i     (data_i),
`ifdef AIRI5C_PREBUF_ERR_EN
        .err_i      (err_in),
        .err_o      (err_out),
`endif
        .free_o     (free_o),
        .consume_i  (consume_i),
        .data_o     (data_o),
        .hw_avail_o (hw_avail_o),
        .level_o    (level_o),
        .hfull_o    (hfull_o)
    );

`ifndef AIRI5C_PREBUF_ERR_EN
    assign err_out = 2'b00;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Compare every output against the scoreboard contents.
    task automatic compare_model(input string tag);
        int          n;
        logic [31:0] exp_data;
        logic [1:0]  exp_err;
        n        = q_hw.size();
        exp_data = '0;
        exp_err  = '0;
        if (n >= 1) begin exp_data[15:0]  = q_hw[0]; exp_err[0] = q_err[0]; end
        if (n >= 2) begin exp_data[31:16] = q_hw[1]; exp_err[1] = q_err[1]; end
        check({tag, ".data"},  data_o, exp_data);
        check({tag, ".avail"}, 32'(hw_avail_o), (n >= 2) ? 32'd2 : 32'(n));
        check({tag, ".level"}, 32'(level_o), 32'(n));
        check({tag, ".free"},  32'(free_o), (n <= 2*D-2) ? 32'd1 : 32'd0);
        check({tag, ".hfull"}, 32'(hfull_o), (n >= D) ? 32'd1 : 32'd0);
`ifdef AIRI5C_PREBUF_ERR_EN
        check({tag, ".err"},   32'(err_out), 32'(exp_err));
`endif
    endtask

    // One clock: drive inputs, apply the same operation to the scoreboard,
    // then idle the inputs and compare one step after the edge.
    task automatic cycle(input string tag, input logic we, input logic [31:0] d,
                         input logic e, input logic [1:0] c, input logic clr);
        int n_req;
        int n_eff;
        int sz;
        bit acc;
        we_i      = we;
        data_i    = d;
        err_in    = e;
        consume_i = c;
        clear_i   = clr;
        sz    = q_hw.size();
        acc   = we && (sz <= 2*D-2);
        n_req = (c == 2'd3) ? 2 : int'(c);
        n_eff = (n_req < ((sz >= 2) ? 2 : sz)) ? n_req : ((sz >= 2) ? 2 : sz);
        @(posedge clk);
        if (clr) begin
            q_hw.delete();
            q_err.delete();
        end else begin
            repeat (n_eff) begin
                void'(q_hw.pop_front());
                void'(q_err.pop_front());
            end
            if (acc) begin
                q_hw.push_back(d[15:0]);  q_err.push_back(e);
                q_hw.push_back(d[31:16]); q_err.push_back(e);
            end
        end
        #1;
        we_i      = 1'b0;
        consume_i = 2'd0;
        clear_i   = 1'b0;
        err_in    = 1'b0;
        compare_model(tag);
    endtask

    initial begin
        rstn_i    = 1'b0;
        clear_i   = 1'b0;
        we_i      = 1'b0;
        data_i    = '0;
        err_in    = 1'b0;
        consume_i = 2'd0;

        // Reset state, checked while reset is held.
        #12;
        check("rst.free",  32'(free_o), 32'd1);
        check("rst.avail", 32'(hw_avail_o), 32'd0);
        check("rst.level", 32'(level_o), 32'd0);
        check("rst.hfull", 32'(hfull_o), 32'd0);
        check("rst.data",  data_o, 32'd0);
        @(negedge clk);
        rstn_i = 1'b1;
        @(posedge clk); #1;
        compare_model("idle");

        // Two words, then consume 1 and 2.
        cycle("w1", 1'b1, 32'h2222_1111, 1'b0, 2'd0, 1'b0);
        cycle("w2", 1'b1, 32'h4444_3333, 1'b0, 2'd0, 1'b0);
        cycle("c1", 1'b0, 32'h0, 1'b0, 2'd1, 1'b0);
        check("c1.data_exp", data_o, 32'h3333_2222);
        cycle("c2", 1'b0, 32'h0, 1'b0, 2'd2, 1'b0);
        check("c2.data_exp",  data_o, 32'h0000_4444);
        check("c2.avail_exp", 32'(hw_avail_o), 32'd1);
        cycle("c3clamp", 1'b0, 32'h0, 1'b0, 2'd3, 1'b0);
        check("empty.level", 32'(level_o), 32'd0);

        // Fill to full; a 5th write is ignored.
        for (int i = 0; i < D; i++)
            cycle("fill", 1'b1, {16'(16'hA000 + 2*i + 1), 16'(16'hA000 + 2*i)}, 1'b0, 2'd0, 1'b0);
        check("full.level", 32'(level_o), 32'd8);
        check("full.free",  32'(free_o), 32'd0);
        check("full.hfull", 32'(hfull_o), 32'd1);
        cycle("full.wr5", 1'b1, 32'hDEAD_BEEF, 1'b0, 2'd0, 1'b0);
        check("full.wr5.level", 32'(level_o), 32'd8);
        // Odd level 7 still refuses writes.
        cycle("odd.c1", 1'b0, 32'h0, 1'b0, 2'd1, 1'b0);
        check("odd.free", 32'(free_o), 32'd0);
        cycle("odd.wr", 1'b1, 32'hBAD0_BAD0, 1'b0, 2'd0, 1'b0);
        check("odd.level", 32'(level_o), 32'd7);
        for (int i = 0; i < D; i++)
            cycle("drain", 1'b0, 32'h0, 1'b0, 2'd2, 1'b0);
        check("drained.level", 32'(level_o), 32'd0);

        // Steady stream at odd offset: window straddles entry 3 -> 0.
        cycle("wr.a", 1'b1, 32'hB001_B000, 1'b0, 2'd0, 1'b0);
        cycle("wr.b", 1'b1, 32'hB003_B002, 1'b0, 2'd0, 1'b0);
        cycle("off1", 1'b0, 32'h0, 1'b0, 2'd1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle("stream", 1'b1, {16'(16'hC000 + 2*i + 1), 16'(16'hC000 + 2*i)}, 1'b0, 2'd2, 1'b0);
            check("stream.level3", 32'(level_o), 32'd3);
        end

        // Clear dominates write and consume at level 5.
        cycle("lvl5", 1'b1, 32'hD001_D000, 1'b0, 2'd0, 1'b0);
        check("lvl5.level", 32'(level_o), 32'd5);
        cycle("clr", 1'b1, 32'hD003_D002, 1'b0, 2'd2, 1'b1);
        check("clr.level", 32'(level_o), 32'd0);
        check("clr.avail", 32'(hw_avail_o), 32'd0);
        check("clr.free",  32'(free_o), 32'd1);

        // Consume of 3 clamps to 2 when plenty is available.
        cycle("cl.w1", 1'b1, 32'hE001_E000, 1'b0, 2'd0, 1'b0);
        cycle("cl.w2", 1'b1, 32'hE003_E002, 1'b0, 2'd0, 1'b0);
        cycle("cl.c3", 1'b0, 32'h0, 1'b0, 2'd3, 1'b0);
        check("cl.c3.level", 32'(level_o), 32'd2);

        // Error bits: word 2 flagged, others clean.
        cycle("e.clr", 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
        cycle("e.w1", 1'b1, 32'hF001_F000, 1'b0, 2'd0, 1'b0);
        cycle("e.w2", 1'b1, 32'hF003_F002, 1'b1, 2'd0, 1'b0);
        cycle("e.w3", 1'b1, 32'hF005_F004, 1'b0, 2'd0, 1'b0);
        cycle("e.w4", 1'b1, 32'hF007_F006, 1'b0, 2'd0, 1'b0);
        cycle("e.off2", 1'b0, 32'h0, 1'b0, 2'd2, 1'b0);
        cycle("e.off3", 1'b0, 32'h0, 1'b0, 2'd1, 1'b0);
`ifdef AIRI5C_PREBUF_ERR_EN
        check("e.off3.err", 32'(err_out), 32'h1);
`endif
        cycle("e.off4", 1'b0, 32'h0, 1'b0, 2'd1, 1'b0);
`ifdef AIRI5C_PREBUF_ERR_EN
        check("e.off4.err", 32'(err_out), 32'h0);
`endif

        // Randomised traffic against the scoreboard.
        for (int i = 0; i < 300; i++)
            cycle("rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 31) == 0));

        // Asynchronous reset mid-operation.
        cycle("pre.rst1", 1'b1, 32'h1234_5678, 1'b0, 2'd0, 1'b0);
        cycle("pre.rst2", 1'b1, 32'h9ABC_DEF0, 1'b0, 2'd0, 1'b0);
        rstn_i = 1'b0;
        #1;
        check("mrst.level", 32'(level_o), 32'd0);
        check("mrst.data",  data_o, 32'd0);
        check("mrst.free",  32'(free_o), 32'd1);
        q_hw.delete();
        q_err.delete();
        @(negedge clk);
        rstn_i = 1'b1;
        @(posedge clk); #1;
        compare_model("post.rst");
        cycle("post.w", 1'b1, 32'h5555_6666, 1'b0, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
